// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing core: packed config layout, timing set and derived span
// boundaries, plus the pack/unpack/check helpers used by config sources.
package vga_timing_pkg;

    localparam int TIM_CW = 12;
    localparam int TIM_W  = 8*TIM_CW + 2;

    // LSB offsets of each field inside cfg_timing
    localparam int OFS_V_FRONT = 0;
    localparam int OFS_V_VIS   = 1*TIM_CW;
    localparam int OFS_V_BACK  = 2*TIM_CW;
    localparam int OFS_V_SYNC  = 3*TIM_CW;
    localparam int OFS_H_FRONT = 4*TIM_CW;
    localparam int OFS_H_VIS   = 5*TIM_CW;
    localparam int OFS_H_BACK  = 6*TIM_CW;
    localparam int OFS_H_SYNC  = 7*TIM_CW;
    localparam int OFS_VS_POL  = 8*TIM_CW;
    localparam int OFS_HS_POL  = 8*TIM_CW + 1;

    localparam logic [TIM_CW+1:0] MAX_TOT = (TIM_CW+2)'(2**TIM_CW - 1);

    typedef struct packed {
        logic              hs_pol;
        logic              vs_pol;
        logic [TIM_CW-1:0] h_sync;
        logic [TIM_CW-1:0] h_back;
        logic [TIM_CW-1:0] h_vis;
        logic [TIM_CW-1:0] h_front;
        logic [TIM_CW-1:0] v_sync;
        logic [TIM_CW-1:0] v_back;
        logic [TIM_CW-1:0] v_vis;
        logic [TIM_CW-1:0] v_front;
    } timing_t;

    // Segment boundaries: start/end of the visible window (end exclusive) and last counter value
    typedef struct packed {
        logic [TIM_CW-1:0] h_sync;
        logic [TIM_CW-1:0] h_start;
        logic [TIM_CW-1:0] h_end;
        logic [TIM_CW-1:0] h_last;
        logic [TIM_CW-1:0] v_sync;
        logic [TIM_CW-1:0] v_start;
        logic [TIM_CW-1:0] v_end;
        logic [TIM_CW-1:0] v_last;
    } span_t;

    function automatic logic [TIM_W-1:0] pack_timing(input timing_t t);
        return t;
    endfunction

    function automatic timing_t unpack_timing(input logic [TIM_W-1:0] v);
        return timing_t'(v);
    endfunction

    function automatic logic timing_ok(input timing_t t);
        logic [TIM_CW+1:0] h_tot;
        logic [TIM_CW+1:0] v_tot;
        h_tot = {2'b00, t.h_sync} + {2'b00, t.h_back} + {2'b00, t.h_vis} + {2'b00, t.h_front};
        v_tot = {2'b00, t.v_sync} + {2'b00, t.v_back} + {2'b00, t.v_vis} + {2'b00, t.v_front};
        return (t.h_sync != '0) && (t.h_vis != '0) && (t.v_sync != '0) && (t.v_vis != '0)
            && (h_tot <= MAX_TOT) && (v_tot <= MAX_TOT);
    endfunction

    function automatic span_t derive_spans(input timing_t t);
        span_t             s;
        logic [TIM_CW+1:0] hb, he, ht, vb, ve, vt;
        hb = {2'b00, t.h_sync} + {2'b00, t.h_back};
        he = hb + {2'b00, t.h_vis};
        ht = he + {2'b00, t.h_front};
        vb = {2'b00, t.v_sync} + {2'b00, t.v_back};
        ve = vb + {2'b00, t.v_vis};
        vt = ve + {2'b00, t.v_front};
        s.h_sync  = t.h_sync;
        s.h_start = TIM_CW'(hb);
        s.h_end   = TIM_CW'(he);
        s.h_last  = TIM_CW'(ht - (TIM_CW+2)'(1));
        s.v_sync  = t.v_sync;
        s.v_start = TIM_CW'(vb);
        s.v_end   = TIM_CW'(ve);
        s.v_last  = TIM_CW'(vt - (TIM_CW+2)'(1));
        return s;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain with a caller-supplied reset value; DEPTH=0 is a straight wire.
module vga_delay_line #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_chain
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_core.sv
// VGA/LCD timing generator: h/v counters, shadowed run-time mode switch at frame end, and a
// pixel-request stream leading the hs/vs/blank_n pins by LEAD clocks.
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int CW      = TIM_CW,  // must equal TIM_CW: packed layout is shared with sources
    parameter int LEAD    = 2,
    parameter int H_SYNC  = 88,
    parameter int H_BACK  = 47,
    parameter int H_VIS   = 800,
    parameter int H_FRONT = 40,
    parameter int V_SYNC  = 3,
    parameter int V_BACK  = 31,
    parameter int V_VIS   = 480,
    parameter int V_FRONT = 13,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [8*CW+1:0] cfg_timing,
    output logic            cfg_err,
    output logic            cfg_applied,
    output logic            req_valid,
    output logic [CW-1:0]   req_x,
    output logic [CW-1:0]   req_y,
    output logic            sof,
    output logic [15:0]     frame_cnt,
    output logic            hs,
    output logic            vs,
    output logic            blank_n
);

    localparam timing_t DEF_T = {1'(HS_POL), 1'(VS_POL),
                                 CW'(H_SYNC), CW'(H_BACK), CW'(H_VIS), CW'(H_FRONT),
                                 CW'(V_SYNC), CW'(V_BACK), CW'(V_VIS), CW'(V_FRONT)};
    localparam span_t   DEF_S   = derive_spans(DEF_T);
    localparam logic    HS_IDLE = (HS_POL == 0);
    localparam logic    VS_IDLE = (VS_POL == 0);

    timing_t       act_t, shd_t, cfg_t;
    span_t         act_s, shd_s;
    logic          pending, apply_q, take, cfg_ok;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap;
    logic          in_hs, in_vs, in_hv, in_vv, in_vis, at_origin;
    logic          hs_q, vs_q;

    assign cfg_t     = unpack_timing(cfg_timing);
    assign cfg_ok    = timing_ok(cfg_t);
    assign cfg_ready = ~pending;
    assign take      = cfg_valid & ~pending;
    assign h_wrap    = (h_cnt == act_s.h_last);
    assign v_wrap    = (v_cnt == act_s.v_last);

    // Shadow swap happens on the wrap edge; cfg_applied and the pending clear follow one clock
    // later so they line up with the registered sof of the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_t       <= DEF_T;
            act_s       <= DEF_S;
            shd_t       <= '0;
            shd_s       <= '0;
            pending     <= 1'b0;
            apply_q     <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_applied <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
        end else begin
            cfg_err     <= take & ~cfg_ok;
            cfg_applied <= apply_q;
            apply_q     <= 1'b0;
            if (take && cfg_ok) begin
                shd_t   <= cfg_t;
                shd_s   <= derive_spans(cfg_t);
                pending <= 1'b1;
            end else if (apply_q) begin
                pending <= 1'b0;
            end
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                    if (pending) begin
                        act_t   <= shd_t;
                        act_s   <= shd_s;
                        apply_q <= 1'b1;
                    end
                end else begin
                    v_cnt <= v_cnt + CW'(1);
                end
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end
    end

    assign in_hs     = (h_cnt < act_s.h_sync);
    assign in_vs     = (v_cnt < act_s.v_sync);
    assign in_hv     = (h_cnt >= act_s.h_start) && (h_cnt < act_s.h_end);
    assign in_vv     = (v_cnt >= act_s.v_start) && (v_cnt < act_s.v_end);
    assign in_vis    = in_hv & in_vv;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_valid <= 1'b0;
            req_x     <= '0;
            req_y     <= '0;
            sof       <= 1'b0;
            frame_cnt <= '0;
            hs_q      <= HS_IDLE;
            vs_q      <= VS_IDLE;
        end else begin
            req_valid <= in_vis;
            req_x     <= in_vis ? h_cnt - act_s.h_start : '0;
            req_y     <= in_vis ? v_cnt - act_s.v_start : '0;
            sof       <= at_origin;
            if (at_origin) frame_cnt <= frame_cnt + 16'd1;
            hs_q      <= in_hs ? act_t.hs_pol : ~act_t.hs_pol;
            vs_q      <= in_vs ? act_t.vs_pol : ~act_t.vs_pol;
        end
    end

    vga_delay_line #(.W(3), .DEPTH(LEAD)) u_pin_delay (
        .clk     (clk),
        .reset   (reset),
        .rst_val ({HS_IDLE, VS_IDLE, 1'b0}),
        .d       ({hs_q, vs_q, req_valid}),
        .q       ({hs, vs, blank_n})
    );

endmodule
